// File: rtl/router_1_to_n_buffered_if.sv
// Bundle of the router's input handshake, output channels and status flags.
// The master side drives words in and consumes channels; the slave side is the router.
interface router_1_to_n_buffered_if #(
  parameter int WIDTH = 8,
  parameter int N     = 8
);
  localparam int SELW = $clog2(N);

  logic               enable;
  logic               bcast;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [SELW-1:0]    s;
  logic [N*WIDTH-1:0] y;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [N-1:0]       full;
  logic               sel_err;

  modport master (
    output enable, bcast, in_valid, x, s, out_ready,
    input  in_ready, y, out_valid, full, sel_err
  );

  modport slave (
    input  enable, bcast, in_valid, x, s, out_ready,
    output in_ready, y, out_valid, full, sel_err
  );
endinterface

// File: rtl/router_1_to_n_buffered.sv
// One-to-N router with an independent first-word-fall-through FIFO per channel.
// A word goes to channel s, to every channel when bcast is set, or is dropped
// with a one-cycle sel_err pulse when s names a channel that does not exist.
module router_1_to_n_buffered #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int DEPTH = 4,
  localparam int SELW = $clog2(N)
) (
  input logic                    clk,
  input logic                    rst_n,
  router_1_to_n_buffered_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

  logic [WIDTH-1:0] mem [N][DEPTH];
  ptr_t             rd_ptr [N];
  ptr_t             wr_ptr [N];
  cnt_t             count  [N];

  logic [N-1:0] sel_onehot;
  logic [N-1:0] push;
  logic [N-1:0] pop;
  logic [N-1:0] full_int;
  logic [N-1:0] valid_int;
  logic         accept;
  logic         sel_err_d;
  logic         sel_err_q;

  // Decode the select into a one-hot channel mask; all-zero means out of range.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_onehot = '0;
    for (int i = 0; i < N; i++) begin
      sel_onehot[i] = (bus.s == SELW'(i));
    end
  end

  // Per-channel status flags derived from occupancy.
  always_comb begin
    full_int  = '0;
    valid_int = '0;
    for (int i = 0; i < N; i++) begin
      full_int[i]  = (count[i] == DEPTH_CNT);
      valid_int[i] = (count[i] != '0);
    end
  end

  // Ready looks only at full, so a pop on a full channel never admits a same-cycle push.
  always_comb begin
    bus.in_ready = 1'b0;
    if (rst_n && bus.enable) begin
      if (bus.bcast) begin
        bus.in_ready = ~|full_int;
      end else begin
        // An out-of-range select masks nothing, so the word is taken and dropped.
        bus.in_ready = ~|(full_int & sel_onehot);
      end
    end
  end

  assign accept = bus.in_valid && bus.in_ready;

  // Push/pop strobes per channel and the drop indication for a bad select.
  always_comb begin
    push      = '0;
    pop       = '0;
    sel_err_d = 1'b0;
    if (accept) begin
      push      = bus.bcast ? '1 : sel_onehot;
      sel_err_d = !bus.bcast && (sel_onehot == '0);
    end
    pop = valid_int & bus.out_ready;
  end

  // Pointer, occupancy and error-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      sel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + ptr_t'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + ptr_t'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + cnt_t'(1);
          2'b01:   count[i] <= count[i] - cnt_t'(1);
          default: count[i] <= count[i];
        endcase
      end
      sel_err_q <= sel_err_d;
    end
  end

  // Word storage: written on push only.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy gates every read, so stale contents are never visible.
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.x;
    end
  end

  // Present each channel's head word, forced to zero while the channel is empty.
  always_comb begin
    bus.y = '0;
    for (int i = 0; i < N; i++) begin
      bus.y[i*WIDTH +: WIDTH] = valid_int[i] ? mem[i][rd_ptr[i]] : '0;
    end
  end

  assign bus.out_valid = valid_int;
  assign bus.full      = full_int;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_router_1_to_n_buffered.sv
// Directed bench for router_1_to_n_buffered: a vector table for single route,
// fill/backpressure and drain, then hand sequences for broadcast, push/pop
// wrap, mid-traffic reset and an out-of-range select on a six-channel instance.
module tb_router_1_to_n_buffered;
  logic clk;
  logic rst_n8;
  logic rst_n6;

  int checks = 0;
  int errors = 0;

  router_1_to_n_buffered_if #(.WIDTH(8), .N(8)) b8 ();
  router_1_to_n_buffered_if #(.WIDTH(8), .N(6)) b6 ();

  router_1_to_n_buffered #(.WIDTH(8), .N(8), .DEPTH(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .bus   (b8)
  );

  router_1_to_n_buffered #(.WIDTH(8), .N(6), .DEPTH(4)) dut6 (
    .clk   (clk),
    .rst_n (rst_n6),
    .bus   (b6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        enable;
    logic        bcast;
    logic        in_valid;
    logic [7:0]  x;
    logic [2:0]  s;
    logic [7:0]  out_ready;
    logic        exp_ready;
    logic [7:0]  exp_valid;
    logic [7:0]  exp_full;
    logic [63:0] exp_y;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic en, input logic bc, input logic iv,
                        input logic [7:0] xv, input logic [2:0] sv, input logic [7:0] orv);
    b8.enable    = en;
    b8.bcast     = bc;
    b8.in_valid  = iv;
    b8.x         = xv;
    b8.s         = sv;
    b8.out_ready = orv;
  endtask

  initial begin
    //          rst en bc iv  x      s     or      rdy valid   full    y
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 64'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 3'd3, 8'h00, 1'b1, 8'h08, 8'h00, 64'h0000_0000_A500_0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 8'h08, 1'b1, 8'h00, 8'h00, 64'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 3'd2, 8'h00, 1'b1, 8'h04, 8'h00, 64'h0000_0000_0001_0000};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 3'd2, 8'h00, 1'b1, 8'h04, 8'h00, 64'h0000_0000_0001_0000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 3'd2, 8'h00, 1'b1, 8'h04, 8'h00, 64'h0000_0000_0001_0000};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 3'd2, 8'h00, 1'b1, 8'h04, 8'h04, 64'h0000_0000_0001_0000};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 3'd2, 8'h00, 1'b0, 8'h04, 8'h04, 64'h0000_0000_0001_0000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 3'd2, 8'h04, 1'b0, 8'h04, 8'h00, 64'h0000_0000_0002_0000};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 8'h04, 1'b1, 8'h04, 8'h00, 64'h0000_0000_0003_0000};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 8'h04, 1'b1, 8'h04, 8'h00, 64'h0000_0000_0004_0000};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 8'h04, 1'b1, 8'h00, 8'h00, 64'h0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 3'd6, 8'h00, 1'b1, 8'h00, 8'h00, 64'h0};

    // Six-channel instance idles in reset until its own sequence.
    rst_n6       = 1'b0;
    b6.enable    = 1'b0;
    b6.bcast     = 1'b0;
    b6.in_valid  = 1'b0;
    b6.x         = 8'h00;
    b6.s         = 3'd0;
    b6.out_ready = 6'h00;

    // Table: single route, fill/backpressure, drain with enable low, idle inputs.
    for (int i = 0; i < 13; i++) begin
      rst_n8 = vecs[i].rst_n;
      drive8(vecs[i].enable, vecs[i].bcast, vecs[i].in_valid,
             vecs[i].x, vecs[i].s, vecs[i].out_ready);
      #1;
      check($sformatf("vec%0d in_ready", i), 64'(b8.in_ready), 64'(vecs[i].exp_ready));
      tick();
      check($sformatf("vec%0d out_valid", i), 64'(b8.out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d full", i), 64'(b8.full), 64'(vecs[i].exp_full));
      check($sformatf("vec%0d y", i), b8.y, vecs[i].exp_y);
      check($sformatf("vec%0d sel_err", i), 64'(b8.sel_err), 64'h0);
    end

    // Broadcast blocked by a full channel 5, even while channel 5 pops.
    for (int k = 0; k < 4; k++) begin
      drive8(1'b1, 1'b0, 1'b1, 8'h50 + 8'(k), 3'd5, 8'h00);
      tick();
    end
    check("bc full5", 64'(b8.full), 64'h20);
    drive8(1'b1, 1'b1, 1'b1, 8'h3C, 3'd0, 8'h20);
    #1;
    check("bc ready while full", 64'(b8.in_ready), 64'h0);
    tick();
    check("bc after pop full", 64'(b8.full), 64'h00);
    check("bc after pop valid", 64'(b8.out_valid), 64'h20);
    b8.out_ready = 8'h00;
    #1;
    check("bc ready after pop", 64'(b8.in_ready), 64'h1);
    tick();
    check("bc all valid", 64'(b8.out_valid), 64'hFF);
    check("bc y", b8.y, 64'h3C3C_513C_3C3C_3C3C);
    drive8(1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 8'hFF);
    tick();
    check("bc drain valid", 64'(b8.out_valid), 64'h20);
    check("bc drain y", b8.y, 64'h0000_5200_0000_0000);
    b8.out_ready = 8'h20;
    tick();
    tick();
    check("bc ch5 head 3C", 64'(b8.y[47:40]), 64'h3C);
    tick();
    check("bc drained", 64'(b8.out_valid), 64'h00);

    // Channel 0 holds two words while pushing and popping every cycle across a wrap.
    drive8(1'b1, 1'b0, 1'b1, 8'h10, 3'd0, 8'h00);
    tick();
    b8.x = 8'h11;
    tick();
    for (int k = 0; k < 10; k++) begin
      drive8(1'b1, 1'b0, 1'b1, 8'h12 + 8'(k), 3'd0, 8'h01);
      #1;
      check($sformatf("pp%0d ready", k), 64'(b8.in_ready), 64'h1);
      check($sformatf("pp%0d head pre", k), 64'(b8.y[7:0]), 64'(8'h10 + 8'(k)));
      tick();
      check($sformatf("pp%0d valid", k), 64'(b8.out_valid), 64'h01);
      check($sformatf("pp%0d full", k), 64'(b8.full), 64'h00);
    end
    drive8(1'b0, 1'b0, 1'b1, 8'hEE, 3'd0, 8'h01);
    #1;
    check("pp disabled ready", 64'(b8.in_ready), 64'h0);
    tick();
    check("pp drain head", 64'(b8.y[7:0]), 64'h1B);
    check("pp drain valid", 64'(b8.out_valid), 64'h01);
    tick();
    check("pp drained", 64'(b8.out_valid), 64'h00);

    // Reset while three channels hold words, with an input word offered.
    for (int k = 0; k < 3; k++) begin
      drive8(1'b1, 1'b0, 1'b1, 8'h11 * 8'(k + 1), (k == 0) ? 3'd1 : (k == 1) ? 3'd4 : 3'd6, 8'h00);
      tick();
    end
    check("rst pre valid", 64'(b8.out_valid), 64'h52);
    rst_n8 = 1'b0;
    drive8(1'b1, 1'b0, 1'b1, 8'h77, 3'd0, 8'h00);
    #1;
    check("rst in_ready", 64'(b8.in_ready), 64'h0);
    tick();
    check("rst valid", 64'(b8.out_valid), 64'h00);
    check("rst full", 64'(b8.full), 64'h00);
    check("rst y", b8.y, 64'h0);
    rst_n8 = 1'b1;
    drive8(1'b1, 1'b0, 1'b1, 8'hE7, 3'd7, 8'h00);
    #1;
    check("post rst ready", 64'(b8.in_ready), 64'h1);
    tick();
    check("post rst valid", 64'(b8.out_valid), 64'h80);
    check("post rst y", b8.y, 64'hE700_0000_0000_0000);

    // Out-of-range select on six channels: taken, dropped, one-cycle sel_err.
    rst_n6 = 1'b1;
    b6.enable   = 1'b1;
    b6.in_valid = 1'b1;
    b6.x        = 8'h22;
    b6.s        = 3'd2;
    tick();
    check("bad pre valid", 64'(b6.out_valid), 64'h04);
    b6.x = 8'h99;
    b6.s = 3'd7;
    #1;
    check("bad ready", 64'(b6.in_ready), 64'h1);
    check("bad sel_err idle", 64'(b6.sel_err), 64'h0);
    tick();
    check("bad sel_err pulse", 64'(b6.sel_err), 64'h1);
    check("bad valid unchanged", 64'(b6.out_valid), 64'h04);
    check("bad y unchanged", 64'(b6.y), 64'h0000_0022_0000);
    b6.in_valid = 1'b0;
    tick();
    check("bad sel_err clear", 64'(b6.sel_err), 64'h0);
    check("bad valid final", 64'(b6.out_valid), 64'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
